// File: rtl/par_addsub_pipe.sv
// Pipelined chunked add/sub; ADDSUB_SAT_EN clamps sum to signed limits on overflow.
// Latency STAGES cycles, 1 beat/cycle.
// Backpressure: whole pipe advances only when the output slot is empty or taken.
module par_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic              adv;
  logic [WIDTH-1:0]  b_x;
  logic              c0;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d, ci;
  logic [WIDTH-1:0]  x_q [STAGES];
  logic [WIDTH-1:0]  x_d [STAGES];
  logic [WIDTH-1:0]  y_q [STAGES];
  logic [WIDTH-1:0]  y_d [STAGES];
  logic [WIDTH-1:0]  xi  [STAGES];
  logic [WIDTH-1:0]  yi  [STAGES];
  logic [CW:0]       t   [STAGES];
  logic              a_msb, b_msb;
  logic              ovf_q, ovf_d;

  assign adv      = !vld_q[LAST] || out_ready;
  assign in_ready = adv;
  assign b_x      = sub ? ~b : b;
  assign c0       = sub | cin;

  if (STAGES == 1) begin : g_vld_single
    assign vld_d = in_valid;
  end else begin : g_vld_shift
    assign vld_d = {vld_q[STAGES-2:0], in_valid};
  end

  // x carries the beat as {finished sum chunks, remaining A chunks}: each stage
  // consumes the low chunk and inserts its sum chunk at the top, so after the
  // last stage x is the complete result. y rotates B' the same way.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] raw;

    if (k == 0) begin : g_first
      assign xi[k] = a;
      assign yi[k] = b_x;
      assign ci[k] = c0;
    end else begin : g_next
      assign xi[k] = x_q[k-1];
      assign yi[k] = y_q[k-1];
      assign ci[k] = c_q[k-1];
    end

    assign t[k]   = {1'b0, xi[k][CW-1:0]} + {1'b0, yi[k][CW-1:0]} + {{CW{1'b0}}, ci[k]};
    assign raw    = (xi[k] >> CW) | (WIDTH'(t[k][CW-1:0]) << (WIDTH - CW));
    assign y_d[k] = (yi[k] >> CW) | (yi[k] << (WIDTH - CW));
    assign c_d[k] = t[k][CW];

    if (k == LAST) begin : g_out
      assign a_msb = xi[k][CW-1];
      assign b_msb = yi[k][CW-1];
      assign ovf_d = (a_msb == b_msb) && (t[k][CW-1] != a_msb);
`ifdef ADDSUB_SAT_EN
      assign x_d[k] = ovf_d ? {a_msb, {(WIDTH-1){~a_msb}}} : raw;
`else
      assign x_d[k] = raw;
`endif
    end else begin : g_mid
      assign x_d[k] = raw;
    end
  end

  // Bubbles load data too; only the valid bits decide what is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign sum       = x_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_par_addsub_pipe.sv
// Scoreboard bench for par_addsub_pipe: one 4-stage DUT under full flow control,
// plus 1-stage and 16-stage DUTs that see the same accepted beats.
module tb_par_addsub_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;
  logic        acc;
  logic        rdy1, ov1, co1, of1;
  logic        rdy2, ov2, co2, of2;
  logic [15:0] sum1, sum2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;
  res_t q0[$];
  res_t q1[$];
  res_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  par_addsub_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  assign acc = in_valid && in_ready;

  par_addsub_pipe #(.WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(acc), .in_ready(rdy1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(1'b1),
    .sum(sum1), .cout(co1), .ovf(of1));

  par_addsub_pipe #(.WIDTH(16), .STAGES(16)) dut_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(acc), .in_ready(rdy2),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(1'b1),
    .sum(sum2), .cout(co2), .ovf(of2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [15:0] aa, input logic [15:0] bb,
                                 input logic ci, input logic sb);
    logic [15:0] bx;
    logic [16:0] f;
    res_t r;
    bx   = sb ? ~bb : bb;
    f    = {1'b0, aa} + {1'b0, bx} + {16'd0, (sb | ci)};
    r.s  = f[15:0];
    r.co = f[16];
    r.ov = (aa[15] == bx[15]) && (f[15] != aa[15]);
`ifdef ADDSUB_SAT_EN
    if (r.ov) r.s = aa[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] aa, input logic [15:0] bb,
                      input logic ci, input logic sb, input res_t e);
    int  waitc;
    bit  done;
    a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1;
    done = 0; waitc = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q0.push_back(e);
        q1.push_back(e);
        q2.push_back(e);
        done = 1;
      end else if (waitc > 500) begin
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        done = 1;
      end
      waitc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [15:0] aa, bb;
    logic ci, sb;
    aa = 16'($urandom);
    bb = 16'($urandom);
    ci = 1'($urandom_range(0, 1));
    sb = 1'($urandom_range(0, 1));
    send(aa, bb, ci, sb, model(aa, bb, ci, sb));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q2", q2.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Outputs are compared against the queue head every valid cycle, so a
  // stalled beat must hold its value until it is taken.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q0.size() == 0) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("sum", {16'd0, sum}, {16'd0, q0[0].s});
        chk("cout", {31'd0, cout}, {31'd0, q0[0].co});
        chk("ovf", {31'd0, ovf}, {31'd0, q0[0].ov});
        if (out_ready) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1) begin
      if (q1.size() == 0) chk("s1_spurious", {31'd0, ov1}, 32'd0);
      else chk("s1_res", {14'd0, sum1, co1, of1}, {14'd0, q1.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov2) begin
      if (q2.size() == 0) chk("s16_spurious", {31'd0, ov2}, 32'd0);
      else chk("s16_res", {14'd0, sum2, co2, of2}, {14'd0, q2.pop_front()});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   lat;
    bit   seen;
    int   start;
    res_t e;

    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_s16_valid", {31'd0, ov2}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(1);

    // Single beat, latency measured from the driving cycle
    send(16'h1234, 16'h0FFF, 1'b1, 1'b0, res_t'({16'h2234, 2'b00}));
    lat = 1; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    chk("latency", lat, 4);
    @(posedge clk);
    #1;
    drain();

    // Carry ripple and subtraction
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, res_t'({16'h0000, 2'b10}));
    send(16'h0005, 16'h0007, 1'b1, 1'b1, res_t'({16'hFFFE, 2'b00}));

    // Signed overflow in both directions
`ifdef ADDSUB_SAT_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, res_t'({16'h7FFF, 2'b01}));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, res_t'({16'h8000, 2'b11}));
    send(16'h8000, 16'hFFFF, 1'b0, 1'b0, res_t'({16'h8000, 2'b11}));
`else
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, res_t'({16'h8000, 2'b01}));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, res_t'({16'h7FFF, 2'b11}));
    send(16'h8000, 16'hFFFF, 1'b0, 1'b0, res_t'({16'h7FFF, 2'b11}));
`endif
    drain();

    // Back-to-back streaming: 100 beats must take exactly 100 cycles
    start = cyc;
    for (int i = 0; i < 100; i++) send_rand();
    chk("stream_cycles", cyc - start, 100);
    drain();

    // Random valid/ready
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 99) < 70) send_rand();
      else idle(1);
    end
    rdy_mode = 0;
    idle(2);
    drain();

    // Fill under stall, then asynchronous reset mid-stream
    rdy_mode = 2;
    idle(2);
    for (int i = 0; i < 4; i++) send_rand();
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_sum", {16'd0, sum}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
    chk("arst_s16_valid", {31'd0, ov2}, 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    rdy_mode = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(10);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Recovery after reset
    e = model(16'h1234, 16'h0FFF, 1'b1, 1'b0);
    send(16'h1234, 16'h0FFF, 1'b1, 1'b0, e);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, res_t'({16'hFFFE, 2'b00}));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
